// File: rtl/exp5_unidade_controle_rodadas.sv
// Round-based control unit for the memory-sequence game.
// Sequences the address counter (E), round-limit counter (L), switch register (R)
// and the memory comparator; reports win, wrong move or move timeout.
// Optional feature macro: TIMEOUT_EN (per-move timeout counter and fim_timeout state).
module exp5_unidade_controle_rodadas #(
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout_out,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE,
        FIM_ACERTOU    = 4'hF
    } estado_t;

    localparam logic [3:0] DB_ILEGAL = 4'hC;

    estado_t state;
    estado_t state_next;
    logic    expirou;

`ifdef TIMEOUT_EN
    localparam int unsigned TIMER_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    logic [TIMER_W-1:0] timer;

    assign expirou = (timer == TIMER_W'(TIMEOUT_CICLOS - 1));

    // Per-move timer: counts idle cycles in espera_jogada, cleared elsewhere; stops at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (state != ESPERA_JOGADA) begin
            timer <= '0;
        end else if (!jogada && !expirou) begin
            timer <= timer + TIMER_W'(1);
        end
    end
`else
    assign expirou = 1'b0;

    // Without the timer the move window is unbounded; TIMEOUT_CICLOS has no effect.
    if (TIMEOUT_CICLOS < 2) begin : g_timeout_sem_efeito
    end
`endif

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            INICIAL:        if (iniciar) state_next = PREPARACAO;
            PREPARACAO:     state_next = INICIA_RODADA;
            INICIA_RODADA:  state_next = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada)       state_next = REGISTRA;
                else if (expirou) state_next = FIM_TIMEOUT;
            end
            REGISTRA:       state_next = COMPARACAO;
            COMPARACAO: begin
                if (!chavesIgualMemoria) state_next = FIM_ERROU;
                else if (!fimE)          state_next = PROXIMA_JOGADA;
                else if (!fimL)          state_next = PROXIMA_RODADA;
                else                     state_next = FIM_ACERTOU;
            end
            PROXIMA_JOGADA: state_next = ESPERA_JOGADA;
            PROXIMA_RODADA: state_next = INICIA_RODADA;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:    if (iniciar) state_next = PREPARACAO;
            default:        state_next = INICIAL;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraL       = 1'b0;
        contaL      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        pronto      = 1'b0;
        ganhou      = 1'b0;
        perdeu      = 1'b0;
        timeout_out = 1'b0;
        db_estado   = state;
        case (state)
            INICIAL, PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
            end
            INICIA_RODADA:  zeraE = 1'b1;
            ESPERA_JOGADA:  ;
            REGISTRA:       registraR = 1'b1;
            COMPARACAO:     ;
            PROXIMA_JOGADA: contaE = 1'b1;
            PROXIMA_RODADA: contaL = 1'b1;
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto = 1'b1;
`ifdef TIMEOUT_EN
                timeout_out = 1'b1;
`endif
            end
            default:        db_estado = DB_ILEGAL;
        endcase
    end

endmodule

// File: tb/tb_exp5_unidade_controle_rodadas.sv
// Directed self-checking bench for exp5_unidade_controle_rodadas (TIMEOUT_CICLOS = 10).
module tb_exp5_unidade_controle_rodadas;

    localparam int unsigned TO = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       chavesIgualMemoria;
    logic       fimE;
    logic       fimL;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       pronto, ganhou, perdeu, timeout_out;
    logic [3:0] db_estado;

    int n_chk  = 0;
    int n_pass = 0;

    exp5_unidade_controle_rodadas #(.TIMEOUT_CICLOS(TO)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .jogada             (jogada),
        .chavesIgualMemoria (chavesIgualMemoria),
        .fimE               (fimE),
        .fimL               (fimL),
        .zeraE              (zeraE),
        .contaE             (contaE),
        .zeraL              (zeraL),
        .contaL             (contaL),
        .zeraR              (zeraR),
        .registraR          (registraR),
        .pronto             (pronto),
        .ganhou             (ganhou),
        .perdeu             (perdeu),
        .timeout_out        (timeout_out),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Walk inicial/final -> preparacao -> inicia_rodada -> espera_jogada.
    task automatic start_game(input string tag);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check({tag, "_prep"}, 32'(db_estado), 32'h1);
        tick();
        check({tag, "_inicia"}, 32'(db_estado), 32'h2);
        tick();
        check({tag, "_espera"}, 32'(db_estado), 32'h3);
    endtask

    initial begin
        int n_rodadas;
        int n_espera;
        int conta_e_seen;

        reset = 1'b1;
        iniciar = 1'b0;
        jogada = 1'b0;
        chavesIgualMemoria = 1'b0;
        fimE = 1'b0;
        fimL = 1'b0;
        tick();
        tick();
        check("rst_estado", 32'(db_estado), 32'h0);
        check("rst_zeras", 32'({zeraE, zeraL, zeraR}), 32'b111);
        check("rst_outros", 32'({contaE, contaL, registraR, pronto, ganhou, perdeu, timeout_out}), 32'h0);
        reset = 1'b0;
        tick();
        check("idle_inicial", 32'(db_estado), 32'h0);

        // Full win over 4 rounds.
        start_game("win");
        n_rodadas = 0;
        for (int r = 0; r < 4; r++) begin
            for (int m = 0; m <= r; m++) begin
                jogada = 1'b1;
                chavesIgualMemoria = 1'b1;
                fimE = (m == r);
                fimL = (r == 3);
                tick();
                jogada = 1'b0;
                check("win_registra", 32'({db_estado, registraR}), 32'({4'h4, 1'b1}));
                tick();
                check("win_comparacao", 32'(db_estado), 32'h5);
                tick();
                if (m < r) begin
                    check("win_prox_jogada", 32'({db_estado, contaE}), 32'({4'h6, 1'b1}));
                    tick();
                    check("win_volta_espera", 32'(db_estado), 32'h3);
                end else if (r < 3) begin
                    check("win_prox_rodada", 32'({db_estado, contaL}), 32'({4'h7, 1'b1}));
                    n_rodadas++;
                    tick();
                    check("win_inicia_rodada", 32'({db_estado, zeraE}), 32'({4'h2, 1'b1}));
                    tick();
                    check("win_espera_rodada", 32'(db_estado), 32'h3);
                end
            end
        end
        check("win_rodadas", 32'(n_rodadas), 32'd3);
        check("win_final", 32'({db_estado, pronto, ganhou, perdeu, timeout_out}), 32'({4'hF, 4'b1100}));
        chavesIgualMemoria = 1'b0;
        fimE = 1'b0;
        fimL = 1'b0;
        jogada = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        jogada = 1'b0;
        check("win_hold", 32'({db_estado, pronto, ganhou}), 32'({4'hF, 2'b11}));

        // Loss: round 0 ok, round 1 second move wrong.
        start_game("loss");
        jogada = 1'b1; chavesIgualMemoria = 1'b1; fimE = 1'b1; fimL = 1'b0;
        tick(); jogada = 1'b0; tick(); tick();
        check("loss_r0_prox_rodada", 32'(db_estado), 32'h7);
        tick(); tick();
        check("loss_r1_espera", 32'(db_estado), 32'h3);
        jogada = 1'b1; fimE = 1'b0;
        tick(); jogada = 1'b0; tick(); tick();
        check("loss_r1_m0", 32'({db_estado, contaE}), 32'({4'h6, 1'b1}));
        tick();
        jogada = 1'b1; chavesIgualMemoria = 1'b0; fimE = 1'b1;
        conta_e_seen = 0;
        tick(); jogada = 1'b0;
        conta_e_seen += int'(contaE);
        check("loss_registra", 32'(db_estado), 32'h4);
        tick();
        conta_e_seen += int'(contaE);
        tick();
        conta_e_seen += int'(contaE);
        check("loss_final", 32'({db_estado, pronto, ganhou, perdeu, timeout_out}), 32'({4'hE, 4'b1010}));
        tick();
        conta_e_seen += int'(contaE);
        check("loss_no_contaE", 32'(conta_e_seen), 32'd0);
        check("loss_hold", 32'(db_estado), 32'hE);

`ifdef TIMEOUT_EN
        // Timeout after exactly TO cycles in espera_jogada.
        start_game("to");
        n_espera = 1;
        for (int i = 0; i < 50 && db_estado == 4'h3; i++) begin
            tick();
            if (db_estado == 4'h3) n_espera++;
        end
        check("to_ciclos_espera", 32'(n_espera), 32'(TO));
        check("to_final", 32'({db_estado, pronto, ganhou, perdeu, timeout_out}), 32'({4'hD, 4'b1001}));

        // Jogada on the last allowed cycle wins over expiry.
        start_game("to_jog");
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        check("to_jog_ainda_espera", 32'(db_estado), 32'h3);
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        check("to_jog_registra", 32'({db_estado, timeout_out}), 32'({4'h4, 1'b0}));
`else
        // No timer: wait indefinitely.
        start_game("nto");
        n_espera = 0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (db_estado == 4'h3 && !timeout_out) n_espera++;
        end
        check("nto_espera", 32'(n_espera), 32'd20000);
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        check("nto_registra", 32'(db_estado), 32'h4);
`endif

        // Synchronous reset in comparacao: no effect until the next edge.
        tick();
        check("rst_sync_comparacao", 32'(db_estado), 32'h5);
        reset = 1'b1;
        #2;
        check("rst_sync_sem_borda", 32'(db_estado), 32'h5);
        tick();
        reset = 1'b0;
        check("rst_sync_borda", 32'({db_estado, zeraE, zeraL, zeraR}), 32'({4'h0, 3'b111}));

        // iniciar held in espera_jogada is ignored.
        start_game("ini_mid");
        iniciar = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        iniciar = 1'b0;
        check("ini_mid_ignorado", 32'(db_estado), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
